// File: rtl/branch_pc_ctrl.sv
// Branch resolution and PC-redirect controller: 2-bit predictor table, BEQ/BNE
// resolution in EX, mispredict redirect/flush sequencing and performance counters.
module branch_pc_ctrl #(
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_fetch_pc,
  output logic             o_pred_taken,
  input  logic             i_ex_valid,
  input  logic [31:0]      i_ex_pc,
  input  logic [2:0]       i_ex_funct3,
  input  logic             i_ex_zero,
  input  logic             i_ex_pred,
  output logic             o_redirect,
  output logic             o_redirect_taken,
  input  logic             i_fetch_rdy,
  output logic             o_flush,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int FC_W  = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0]  FC_INIT  = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t            r_state;
  logic [FC_W-1:0]   r_flush_cnt;
  logic [1:0]        r_table [DEPTH];

  logic [IDX_W-1:0]  w_fetch_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [1:0]        w_ex_entry;
  logic [1:0]        w_entry_next;
  logic              w_is_br;
  logic              w_taken;
  logic              w_tracked;
  logic              w_mispred;
  logic              w_unused;

  assign w_fetch_idx  = i_fetch_pc[IDX_W+1:2];
  assign w_ex_idx     = i_ex_pc[IDX_W+1:2];
  assign w_ex_entry   = r_table[w_ex_idx];
  assign o_pred_taken = r_table[w_fetch_idx][1];
  assign w_tracked    = i_ex_valid & w_is_br & (r_state == S_IDLE);
  assign w_mispred    = w_tracked & (w_taken != i_ex_pred);
  assign w_unused     = ^{i_fetch_pc[31:IDX_W+2], i_fetch_pc[1:0],
                          i_ex_pc[31:IDX_W+2], i_ex_pc[1:0]};

  // Decode branch type and actual outcome from funct3 and the ALU zero flag.
  always_comb begin
    w_is_br = 1'b0;
    w_taken = 1'b0;
    case (i_ex_funct3)
      3'b000: begin
        w_is_br = 1'b1;
        w_taken = i_ex_zero;
      end
      3'b001: begin
        w_is_br = 1'b1;
        w_taken = ~i_ex_zero;
      end
      default: begin
        w_is_br = 1'b0;
        w_taken = 1'b0;
      end
    endcase
  end

  // Saturating move of the resolved entry toward the actual outcome.
  always_comb begin
    w_entry_next = w_ex_entry;
    if (w_taken) begin
      if (w_ex_entry != 2'b11) w_entry_next = w_ex_entry + 2'b01;
      else                     w_entry_next = w_ex_entry;
    end else begin
      if (w_ex_entry != 2'b00) w_entry_next = w_ex_entry - 2'b01;
      else                     w_entry_next = w_ex_entry;
    end
  end

  // Predictor table: reset to weak not-taken, written on tracked resolutions.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= 2'b01;
    end else if (w_tracked) begin
      r_table[w_ex_idx] <= w_entry_next;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_branch_cnt  <= CNT_ZERO;
      o_mispred_cnt <= CNT_ZERO;
    end else if (w_tracked) begin
      if (o_branch_cnt != CNT_MAX) o_branch_cnt <= o_branch_cnt + CNT_ONE;
      if (w_mispred && (o_mispred_cnt != CNT_MAX)) o_mispred_cnt <= o_mispred_cnt + CNT_ONE;
    end
  end

  // Recovery FSM; outputs are registered alongside the state so busy tracks it exactly.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_flush_cnt      <= {FC_W{1'b0}};
      o_redirect       <= 1'b0;
      o_redirect_taken <= 1'b0;
      o_flush          <= 1'b0;
      o_busy           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mispred) begin
            r_state          <= S_REDIRECT;
            o_redirect       <= 1'b1;
            o_redirect_taken <= w_taken;
            o_busy           <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (i_fetch_rdy) begin
            o_redirect       <= 1'b0;
            o_redirect_taken <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              r_state <= S_IDLE;
              o_busy  <= 1'b0;
            end else begin
              r_state     <= S_FLUSH;
              r_flush_cnt <= FC_INIT;
              o_flush     <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == FC_ONE) begin
            r_state <= S_IDLE;
            o_flush <= 1'b0;
            o_busy  <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - FC_ONE;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          o_redirect       <= 1'b0;
          o_redirect_taken <= 1'b0;
          o_flush          <= 1'b0;
          o_busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
